// File: rtl/corr_sched.sv
// ----------------------------------------------------------------------------
// corr_sched
//
// Shares one correlation engine between NCH receive channels. Requests are
// queued per channel (at most one outstanding run each), arbitrated
// round-robin, and the granted channel drives the engine's sample-source
// select for the whole run. Each completed run's result is published on
// res_*. The largest signed result since reset is tracked on best_*.
//
// Optional build macro:
//   CORR_TMO_EN  - adds a TMO_W-bit watchdog. A run that sees no eng_rdy
//                  within TMO_MAX WAIT cycles is abandoned with a one-cycle
//                  timeout pulse. Without the macro, WAIT waits indefinitely
//                  and timeout is tied low.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   ena          clock enable; low freezes every register
//   req          per-channel request pulses
//   gnt          one-hot grant, held from ARB exit until the run ends
//   eng_sel      engine sample-source select (granted channel index)
//   eng_start    engine start pulse
//   eng_rdy      engine done pulse; eng_result is valid with it
//   res_valid    one-cycle pulse; res_ch/res_data hold the new result
//   best_ch      channel that produced the largest result since reset
//   best_val     largest result since reset
//   busy         FSM is not idle
//   timeout      one-cycle pulse when a run is abandoned
// ----------------------------------------------------------------------------
module corr_sched #(
    parameter int                 NCH     = 2,
    parameter int                 CH_W    = 1,
    parameter int                 RES_W   = 22,
    parameter int                 TMO_W   = 16,
    parameter logic [TMO_W-1:0]   TMO_MAX = {TMO_W{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [NCH-1:0]          req,
    output logic [NCH-1:0]          gnt,
    output logic [CH_W-1:0]         eng_sel,
    output logic                    eng_start,
    input  logic                    eng_rdy,
    input  logic signed [RES_W-1:0] eng_result,
    output logic                    res_valid,
    output logic [CH_W-1:0]         res_ch,
    output logic signed [RES_W-1:0] res_data,
    output logic [CH_W-1:0]         best_ch,
    output logic signed [RES_W-1:0] best_val,
    output logic                    busy,
    output logic                    timeout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARB     = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_CMP     = 3'd5;
`ifdef CORR_TMO_EN
    localparam logic [2:0] S_TMO     = 3'd6;
`endif

    logic [2:0]      state;
    logic [NCH-1:0]  pending;
    logic [CH_W-1:0] rr;
    logic            best_seen;
    logic            pick_ok;
    logic [CH_W-1:0] pick_idx;
    logic [NCH-1:0]  win_onehot;
    logic [NCH-1:0]  grant_clr;

    // Round-robin search starting one past the last winner. The loop runs
    // from the farthest candidate down to the nearest so the nearest pending
    // channel overwrites any farther one.
    function automatic logic [CH_W:0] rr_pick(input logic [NCH-1:0]  pend,
                                              input logic [CH_W-1:0] ptr);
        logic [CH_W:0]  r;
        logic [NCH-1:0] sh;
        int             idx;
        r = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            sh = pend >> idx;
            if (sh[0]) r = {1'b1, CH_W'(idx)};
        end
        return r;
    endfunction

    // The first result always becomes the best so a negative first peak is
    // not hidden behind the zero reset value. Ties keep the existing best.
    function automatic logic beats_best(input logic signed [RES_W-1:0] cand,
                                        input logic signed [RES_W-1:0] best,
                                        input logic                    seen);
        return !seen || (cand > best);
    endfunction

    assign {pick_ok, pick_idx} = rr_pick(pending, rr);
    assign win_onehot          = NCH'(1) << pick_idx;
    assign grant_clr           = (state == S_ARB && pick_ok) ? win_onehot : '0;

    assign eng_start = (state == S_START);
    assign res_valid = (state == S_CAPTURE);
    assign busy      = (state != S_IDLE);

`ifdef CORR_TMO_EN
    logic [TMO_W-1:0] wdog;
    logic             wdog_hit;

    // Expires once TMO_MAX WAIT cycles have elapsed since START cleared it.
    assign wdog_hit = ({1'b0, wdog} + (TMO_W+1)'(1)) == {1'b0, TMO_MAX};
    assign timeout  = (state == S_TMO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog <= '0;
        end else if (ena) begin
            if (state == S_START)
                wdog <= '0;
            else if (state == S_WAIT && !eng_rdy && !wdog_hit)
                wdog <= wdog + TMO_W'(1);
        end
    end
`else
    logic tmo_unused;
    assign tmo_unused = ^TMO_MAX ^ TMO_W[0];
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pending   <= '0;
            rr        <= CH_W'(NCH - 1);
            gnt       <= '0;
            eng_sel   <= '0;
            res_ch    <= '0;
            res_data  <= '0;
            best_ch   <= '0;
            best_val  <= '0;
            best_seen <= 1'b0;
        end else if (ena) begin
            // A request arriving in the grant cycle re-queues the channel.
            pending <= (pending & ~grant_clr) | req;

            case (state)
                S_IDLE: begin
                    if (pending != '0) state <= S_ARB;
                end
                S_ARB: begin
                    if (pick_ok) begin
                        gnt     <= win_onehot;
                        eng_sel <= pick_idx;
                        rr      <= pick_idx;
                        state   <= S_START;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // eng_rdy takes priority over a coincident watchdog expiry.
                    if (eng_rdy) begin
                        res_data <= eng_result;
                        res_ch   <= eng_sel;
                        state    <= S_CAPTURE;
                    end
`ifdef CORR_TMO_EN
                    else if (wdog_hit) begin
                        state <= S_TMO;
                    end
`endif
                end
                S_CAPTURE: begin
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (beats_best(res_data, best_val, best_seen)) begin
                        best_val  <= res_data;
                        best_ch   <= res_ch;
                        best_seen <= 1'b1;
                    end
                    gnt   <= '0;
                    state <= S_IDLE;
                end
`ifdef CORR_TMO_EN
                S_TMO: begin
                    gnt   <= '0;
                    state <= S_IDLE;
                end
`endif
                default: begin
                    gnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corr_sched.sv
// ----------------------------------------------------------------------------
// tb_corr_sched
//
// Directed bench for corr_sched (NCH=2, RES_W=22, TMO_MAX=100). A small
// behavioural engine is driven by tasks; expected values are hand-derived.
// ----------------------------------------------------------------------------
module tb_corr_sched;

    localparam int NCH   = 2;
    localparam int CH_W  = 1;
    localparam int RES_W = 22;
    localparam int TMO_W = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    ena;
    logic [NCH-1:0]          req;
    logic [NCH-1:0]          gnt;
    logic [CH_W-1:0]         eng_sel;
    logic                    eng_start;
    logic                    eng_rdy;
    logic signed [RES_W-1:0] eng_result;
    logic                    res_valid;
    logic [CH_W-1:0]         res_ch;
    logic signed [RES_W-1:0] res_data;
    logic [CH_W-1:0]         best_ch;
    logic signed [RES_W-1:0] best_val;
    logic                    busy;
    logic                    timeout;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;
    int n_valid  = 0;
    int n_tmo    = 0;

    corr_sched #(
        .NCH(NCH), .CH_W(CH_W), .RES_W(RES_W), .TMO_W(TMO_W), .TMO_MAX(16'd100)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .gnt(gnt), .eng_sel(eng_sel),
        .eng_start(eng_start), .eng_rdy(eng_rdy), .eng_result(eng_result),
        .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
        .best_ch(best_ch), .best_val(best_val), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (eng_start) n_start++;
        if (res_valid) n_valid++;
        if (timeout)   n_tmo++;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout obs=%0d exp=%0d", 1, 0);
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        ena        = 1'b1;
        req        = '0;
        eng_rdy    = 1'b0;
        eng_result = '0;
        rst        = 1'b1;
        tick(2);
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_req(input logic [NCH-1:0] mask);
        req = mask;
        tick();
        req = '0;
    endtask

    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (eng_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("start_seen", int'(ok), 1);
    endtask

    // One engine run: wait for start, hold 'hold' on req while busy,
    // answer after dly cycles, then step through CAPTURE and CMP.
    task automatic run_one(input int ch, input int dly, input int res,
                           input logic [NCH-1:0] hold);
        wait_start();
        check("run_sel", int'(eng_sel), ch);
        check("run_gnt", int'(gnt), 1 << ch);
        req = hold;
        tick(dly);
        eng_rdy    = 1'b1;
        eng_result = RES_W'(res);
        tick();
        eng_rdy = 1'b0;
        req     = '0;
        check("run_valid", int'(res_valid), 1);
        check("run_data", int'(res_data), res);
        check("run_ch", int'(res_ch), ch);
        tick(2);
        check("run_idle_gnt", int'(gnt), 0);
    endtask

    initial begin
        int s0, v0, n;

        // ---- reset state ----
        ena = 1'b1; req = '0; eng_rdy = 1'b0; eng_result = '0; rst = 1'b1;
        #2;
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_best", int'(best_val), 0);
        check("rst_start", int'(eng_start), 0);
        tick(2);
        rst = 1'b0;
        tick();

        // ---- 1: single request, latency, result 1500 ----
        s0 = n_start; v0 = n_valid;
        pulse_req(2'b01);
        check("t1_idle_busy", int'(busy), 0);
        tick();
        check("t1_arb_busy", int'(busy), 1);
        check("t1_arb_start", int'(eng_start), 0);
        tick();
        check("t1_start", int'(eng_start), 1);
        run_one(0, 10, 1500, 2'b00);
        check("t1_best_val", int'(best_val), 1500);
        check("t1_best_ch", int'(best_ch), 0);
        eng_rdy = 1'b1; eng_result = RES_W'(777);
        tick();
        eng_rdy = 1'b0;
        check("t1_stray_rdy", int'(res_valid), 0);
        tick(2);
        check("t1_starts", n_start - s0, 1);
        check("t1_valids", n_valid - v0, 1);

        // ---- 2: simultaneous requests, larger wins, tie keeps ----
        do_reset();
        pulse_req(2'b11);
        run_one(0, 4, 1500, 2'b00);
        check("t2_best_a", int'(best_val), 1500);
        run_one(1, 4, 2100, 2'b00);
        check("t2_best_val", int'(best_val), 2100);
        check("t2_best_ch", int'(best_ch), 1);
        pulse_req(2'b01);
        run_one(0, 3, 2100, 2'b00);
        check("t2_tie_ch", int'(best_ch), 1);
        check("t2_tie_val", int'(best_val), 2100);

        // ---- 3: round-robin alternation with both channels requesting ----
        do_reset();
        pulse_req(2'b01);
        run_one(0, 5, 10, 2'b11);
        run_one(1, 5, 20, 2'b11);
        run_one(0, 5, 30, 2'b00);
        run_one(1, 5, 40, 2'b00);
        tick(3);
        check("t3_drained", int'(busy), 0);
        check("t3_best_ch", int'(best_ch), 1);

        // ---- 4: negative first result ----
        do_reset();
        pulse_req(2'b10);
        run_one(1, 2, -5, 2'b00);
        check("t4_best_val", int'(best_val), -5);
        check("t4_best_ch", int'(best_ch), 1);

        // ---- 5: engine never answers ----
        do_reset();
        v0 = n_valid;
        pulse_req(2'b01);
        wait_start();
`ifdef CORR_TMO_EN
        n = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n++;
            if (timeout) break;
        end
        check("t5_tmo_delay", n, 101);
        tick();
        check("t5_gnt", int'(gnt), 0);
        check("t5_busy", int'(busy), 0);
        eng_rdy = 1'b1; eng_result = RES_W'(999);
        tick();
        eng_rdy = 1'b0;
        tick(3);
        check("t5_tmo_count", n_tmo, 1);
        check("t5_no_valid", n_valid - v0, 0);
        check("t5_best_val", int'(best_val), 0);
`else
        n = 0;
        tick(300);
        check("t5_busy_held", int'(busy), 1);
        check("t5_gnt_held", int'(gnt), 1);
        check("t5_no_tmo", n_tmo, 0);
        check("t5_no_valid", n_valid - v0, 0);
        eng_rdy = 1'b1; eng_result = RES_W'(999);
        tick();
        eng_rdy = 1'b0;
        check("t5_late_valid", int'(res_valid), 1);
        tick(2);
`endif

        // ---- 6: clock enable freeze, then reset mid-run ----
        do_reset();
        v0 = n_valid;
        pulse_req(2'b01);
        wait_start();
        tick(3);
        ena     = 1'b0;
        eng_rdy = 1'b1; eng_result = RES_W'(55);
        tick(5);
        eng_rdy = 1'b0;
        check("t6_frozen_busy", int'(busy), 1);
        check("t6_frozen_gnt", int'(gnt), 1);
        check("t6_frozen_valid", n_valid - v0, 0);
        ena = 1'b1;
        tick(2);
        check("t6_still_wait", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_gnt", int'(gnt), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_sel", int'(eng_sel), 0);
        check("t6_rst_best", int'(best_val), 0);
        tick();
        rst = 1'b0;
        tick(2);
        check("t6_after_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
